// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the two-requester byte-wide memory arbiter:
//     - SIZE_DEFAULT : default address width of the attached memory
//     - state_e      : arbiter FSM state encoding
//     - next_ptr     : round-robin pointer update after a grant
//     - idx_to_onehot: requester index to one-hot pulse vector
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  // Address width of the memory this arbiter is normally paired with.
  localparam int SIZE_DEFAULT = 20;

  // IDLE waits for a request; writes walk WR_LOAD -> WR_DATA, reads use RD.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_LOAD = 2'd1,
    ST_WR_DATA = 2'd2,
    ST_RD      = 2'd3
  } state_e;

  // After granting requester 0 the pointer favours requester 1 and vice
  // versa; the pointer value is simply "index of the favoured requester".
  function automatic logic next_ptr(input logic [1:0] grant);
    return grant[0];
  endfunction

  // One-hot pulse vector for a single requester index.
  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Combinational two-way round-robin picker.
//   Ports:
//     req   [1:0] : request vector, bit i = requester i wants service
//     ptr         : favoured requester when both request (0 or 1)
//     grant [1:0] : one-hot grant, all zero when nobody requests
//   A sole requester always wins regardless of the pointer.
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  // Pick the winner: single requester wins outright, a tie goes to ptr.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one byte-wide asynchronous-style memory (address register load,
//   write strobe, output enable, bidirectional data bus) between two
//   requesters using round-robin arbitration.
//
//   Ports:
//     CLK          : sole clock, all state changes on its rising edge
//     RESET        : synchronous, active-high reset
//     REQ   [1:0]  : access request per requester (sampled only in IDLE)
//     WE    [1:0]  : 1 = write, 0 = read, qualified by REQ
//     ADDR  [2*SIZE-1:0] : requester i address at [i*SIZE +: SIZE]
//     WDATA [15:0] : requester i write byte at [i*8 +: 8]
//     GNT   [1:0]  : one-cycle pulse, request accepted and latched
//     DONE  [1:0]  : one-cycle pulse, access complete
//     RDATA [7:0]  : last read byte, valid with DONE of a read, then held
//     BUSY         : FSM not in IDLE
//     MEM_ADDRESS  : memory address, held between accesses
//     MEM_LOAD     : memory address-register load (write address phase)
//     MEM_WRITE    : memory write strobe (write data phase)
//     MEM_OE       : memory output enable (read)
//     MEM_DATA     : bidirectional data bus, driven only in the data phase
//
//   Timing (edge 0 = accepting edge):
//     write : +1 WR_LOAD (GNT, MEM_LOAD), +2 WR_DATA (MEM_WRITE), +3 DONE
//     read  : +1 RD (GNT, MEM_OE), +2 DONE with RDATA captured at RD exit
//   The DONE cycle is an IDLE cycle, so a still-asserted REQ is accepted on
//   the following edge and service continues without a gap.
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [1:0]        REQ,
  input  logic [1:0]        WE,
  input  logic [2*SIZE-1:0] ADDR,
  input  logic [15:0]       WDATA,
  output logic [1:0]        GNT,
  output logic [1:0]        DONE,
  output logic [7:0]        RDATA,
  output logic              BUSY,
  output logic [SIZE-1:0]   MEM_ADDRESS,
  output logic              MEM_LOAD,
  output logic              MEM_WRITE,
  output logic              MEM_OE,
  inout  wire  [7:0]        MEM_DATA
);

  state_e            state_r;
  logic              ptr_r;
  logic              winner_r;
  logic [7:0]        wdata_r;
  logic [1:0]        gnt_r;
  logic [1:0]        done_r;
  logic [7:0]        rdata_r;
  logic              busy_r;
  logic [SIZE-1:0]   mem_address_r;
  logic              mem_load_r;
  logic              mem_write_r;
  logic              mem_oe_r;

  logic [1:0]        grant_s;
  logic              win_idx_s;
  logic              win_we_s;
  logic [SIZE-1:0]   win_addr_s;
  logic [7:0]        win_wdata_s;

  rr_arb2 u_rr_arb2 (
    .req   (REQ),
    .ptr   (ptr_r),
    .grant (grant_s)
  );

  // Route the winning requester's command fields.
  always_comb begin
    win_idx_s   = grant_s[1];
    win_we_s    = 1'b0;
    win_addr_s  = ADDR[0 +: SIZE];
    win_wdata_s = WDATA[0 +: 8];
    if (win_idx_s) begin
      win_we_s    = WE[1];
      win_addr_s  = ADDR[SIZE +: SIZE];
      win_wdata_s = WDATA[8 +: 8];
    end else begin
      win_we_s    = WE[0];
      win_addr_s  = ADDR[0 +: SIZE];
      win_wdata_s = WDATA[0 +: 8];
    end
  end

  // Arbiter FSM; memory strobes are registered together with the state so
  // they depend on the state register only and never glitch.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r       <= ST_IDLE;
      ptr_r         <= 1'b0;
      winner_r      <= 1'b0;
      wdata_r       <= 8'h00;
      gnt_r         <= 2'b00;
      done_r        <= 2'b00;
      rdata_r       <= 8'h00;
      busy_r        <= 1'b0;
      mem_address_r <= {SIZE{1'b0}};
      mem_load_r    <= 1'b0;
      mem_write_r   <= 1'b0;
      mem_oe_r      <= 1'b0;
    end else begin
      // Pulses default low and are raised only on the relevant transition.
      gnt_r  <= 2'b00;
      done_r <= 2'b00;
      case (state_r)
        ST_IDLE: begin
          if (|REQ) begin
            winner_r      <= win_idx_s;
            ptr_r         <= next_ptr(grant_s);
            gnt_r         <= grant_s;
            mem_address_r <= win_addr_s;
            wdata_r       <= win_wdata_s;
            busy_r        <= 1'b1;
            if (win_we_s) begin
              state_r    <= ST_WR_LOAD;
              mem_load_r <= 1'b1;
              mem_oe_r   <= 1'b0;
            end else begin
              state_r    <= ST_RD;
              mem_load_r <= 1'b0;
              mem_oe_r   <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_WR_LOAD: begin
          state_r     <= ST_WR_DATA;
          mem_load_r  <= 1'b0;
          mem_write_r <= 1'b1;
        end
        ST_WR_DATA: begin
          state_r     <= ST_IDLE;
          mem_write_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= idx_to_onehot(winner_r);
        end
        ST_RD: begin
          // Memory output has been valid for the whole RD cycle.
          state_r  <= ST_IDLE;
          mem_oe_r <= 1'b0;
          rdata_r  <= MEM_DATA;
          busy_r   <= 1'b0;
          done_r   <= idx_to_onehot(winner_r);
        end
        default: begin
          state_r     <= ST_IDLE;
          mem_load_r  <= 1'b0;
          mem_write_r <= 1'b0;
          mem_oe_r    <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Bus is driven only while the write strobe (WR_DATA state) is high.
  assign MEM_DATA = mem_write_r ? wdata_r : 8'bzzzz_zzzz;

  assign GNT         = gnt_r;
  assign DONE        = done_r;
  assign RDATA       = rdata_r;
  assign BUSY        = busy_r;
  assign MEM_ADDRESS = mem_address_r;
  assign MEM_LOAD    = mem_load_r;
  assign MEM_WRITE   = mem_write_r;
  assign MEM_OE      = mem_oe_r;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int SIZE = 20;

  logic              CLK;
  logic              RESET;
  logic [1:0]        REQ;
  logic [1:0]        WE;
  logic [2*SIZE-1:0] ADDR;
  logic [15:0]       WDATA;
  logic [1:0]        GNT;
  logic [1:0]        DONE;
  logic [7:0]        RDATA;
  logic              BUSY;
  logic [SIZE-1:0]   MEM_ADDRESS;
  logic              MEM_LOAD;
  logic              MEM_WRITE;
  logic              MEM_OE;
  wire  [7:0]        MEM_DATA;

  int n_tests;
  int n_fail;

  mem_arbiter #(.SIZE(SIZE)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .REQ         (REQ),
    .WE          (WE),
    .ADDR        (ADDR),
    .WDATA       (WDATA),
    .GNT         (GNT),
    .DONE        (DONE),
    .RDATA       (RDATA),
    .BUSY        (BUSY),
    .MEM_ADDRESS (MEM_ADDRESS),
    .MEM_LOAD    (MEM_LOAD),
    .MEM_WRITE   (MEM_WRITE),
    .MEM_OE      (MEM_OE),
    .MEM_DATA    (MEM_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural memory: address register loaded by MEM_LOAD, written by
  // MEM_WRITE, read combinationally from MEM_ADDRESS while MEM_OE is high.
  logic [7:0]      mem [0:255];
  logic [SIZE-1:0] mem_areg;
  logic            mem_clr;

  always @(posedge CLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else begin
      if (MEM_LOAD)  mem_areg <= MEM_ADDRESS;
      if (MEM_WRITE) mem[mem_areg[7:0]] <= MEM_DATA;
    end
  end

  assign MEM_DATA = MEM_OE ? mem[MEM_ADDRESS[7:0]] : 8'bzzzz_zzzz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] oh(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [19:0] a0;
    logic [19:0] a1;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        win;      // expected winner
    logic        is_wr;    // expected access type
    logic [19:0] exp_addr;
    logic [7:0]  exp_byte; // written byte, or byte expected on RDATA
  } vec_t;

  vec_t vt [10];
  logic [7:0] last_rd;

  task automatic run_vec(input int k, input vec_t v);
    REQ   = v.req;
    WE    = v.we;
    ADDR  = {v.a1, v.a0};
    WDATA = {v.d1, v.d0};
    @(negedge CLK);
    REQ = 2'b00;
    chk($sformatf("v%0d_gnt", k), GNT, oh(v.win));
    chk($sformatf("v%0d_load", k), MEM_LOAD, v.is_wr);
    chk($sformatf("v%0d_oe", k), MEM_OE, !v.is_wr);
    chk($sformatf("v%0d_write1", k), MEM_WRITE, 1'b0);
    chk($sformatf("v%0d_addr", k), MEM_ADDRESS, v.exp_addr);
    chk($sformatf("v%0d_busy", k), BUSY, 1'b1);
    chk($sformatf("v%0d_done_early", k), DONE, 2'b00);
    if (v.is_wr) begin
      @(negedge CLK);
      chk($sformatf("v%0d_write", k), MEM_WRITE, 1'b1);
      chk($sformatf("v%0d_load2", k), MEM_LOAD, 1'b0);
      chk($sformatf("v%0d_oe2", k), MEM_OE, 1'b0);
      chk($sformatf("v%0d_bus", k), MEM_DATA, v.exp_byte);
      chk($sformatf("v%0d_gnt2", k), GNT, 2'b00);
      @(negedge CLK);
      chk($sformatf("v%0d_done", k), DONE, oh(v.win));
      chk($sformatf("v%0d_busy_end", k), BUSY, 1'b0);
      chk($sformatf("v%0d_write_end", k), MEM_WRITE, 1'b0);
      chk($sformatf("v%0d_rdata_hold", k), RDATA, last_rd);
      chk($sformatf("v%0d_mem", k), mem[v.exp_addr[7:0]], v.exp_byte);
    end else begin
      @(negedge CLK);
      chk($sformatf("v%0d_done", k), DONE, oh(v.win));
      chk($sformatf("v%0d_busy_end", k), BUSY, 1'b0);
      chk($sformatf("v%0d_oe_end", k), MEM_OE, 1'b0);
      chk($sformatf("v%0d_rdata", k), RDATA, v.exp_byte);
      last_rd = v.exp_byte;
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_gnt"}, GNT, 2'b00);
    chk({tag, "_done"}, DONE, 2'b00);
    chk({tag, "_busy"}, BUSY, 1'b0);
    chk({tag, "_load"}, MEM_LOAD, 1'b0);
    chk({tag, "_write"}, MEM_WRITE, 1'b0);
    chk({tag, "_oe"}, MEM_OE, 1'b0);
    chk({tag, "_addr"}, MEM_ADDRESS, 20'h00000);
    chk({tag, "_rdata"}, RDATA, 8'h00);
  endtask

  initial begin
    int         pend [$];
    int         gnt_cnt;
    int         done_cnt;
    int         viol;
    int         idx;
    logic       exp_next;
    logic       prev_done;
    logic [1:0] seen;

    n_tests = 0;
    n_fail  = 0;
    last_rd = 8'h00;
    RESET   = 1'b1;
    mem_clr = 1'b1;
    REQ     = 2'b00;
    WE      = 2'b00;
    ADDR    = '0;
    WDATA   = 16'h0000;

    //        req    we     a0         a1         d0     d1     win   wr    addr       byte
    vt[0] = '{2'b01, 2'b01, 20'h00010, 20'h00000, 8'hA5, 8'h00, 1'b0, 1'b1, 20'h00010, 8'hA5};
    vt[1] = '{2'b10, 2'b00, 20'h00000, 20'h00010, 8'h00, 8'h00, 1'b1, 1'b0, 20'h00010, 8'hA5};
    vt[2] = '{2'b11, 2'b11, 20'h00020, 20'h00021, 8'h3C, 8'hC3, 1'b0, 1'b1, 20'h00020, 8'h3C};
    vt[3] = '{2'b11, 2'b00, 20'h00020, 20'h00010, 8'h00, 8'h00, 1'b1, 1'b0, 20'h00010, 8'hA5};
    vt[4] = '{2'b11, 2'b00, 20'h00020, 20'h00010, 8'h00, 8'h00, 1'b0, 1'b0, 20'h00020, 8'h3C};
    vt[5] = '{2'b01, 2'b01, 20'h000FF, 20'h00000, 8'h5A, 8'h00, 1'b0, 1'b1, 20'h000FF, 8'h5A};
    vt[6] = '{2'b11, 2'b10, 20'h00000, 20'h000FF, 8'h00, 8'h81, 1'b1, 1'b1, 20'h000FF, 8'h81};
    vt[7] = '{2'b10, 2'b00, 20'h00000, 20'h000FF, 8'h00, 8'h00, 1'b1, 1'b0, 20'h000FF, 8'h81};
    vt[8] = '{2'b01, 2'b00, 20'h00021, 20'h00000, 8'h00, 8'h00, 1'b0, 1'b0, 20'h00021, 8'h00};
    vt[9] = '{2'b11, 2'b01, 20'h00021, 20'h00020, 8'h99, 8'h00, 1'b1, 1'b0, 20'h00020, 8'h3C};

    // Reset state
    repeat (3) @(negedge CLK);
    RESET   = 1'b0;
    mem_clr = 1'b0;
    chk_idle_zero("reset");

    // Table-driven single transactions
    for (int k = 0; k < 10; k++) run_vec(k, vt[k]);

    // REQ seen while busy is neither served nor queued
    REQ = 2'b01; WE = 2'b01; ADDR = {20'h00000, 20'h00050}; WDATA = 16'h0011;
    @(negedge CLK);
    REQ = 2'b10; WE = 2'b00;
    @(negedge CLK);
    REQ = 2'b00;
    @(negedge CLK);
    chk("busy_req_done", DONE, 2'b01);
    seen = 2'b00;
    repeat (4) begin
      @(negedge CLK);
      seen = seen | GNT;
    end
    chk("busy_req_not_queued", seen, 2'b00);

    // Reset during WR_LOAD abandons the write
    REQ = 2'b01; WE = 2'b01; ADDR = {20'h00000, 20'h00040}; WDATA = 16'h00EE;
    @(negedge CLK);
    chk("rst_wl_load", MEM_LOAD, 1'b1);
    RESET = 1'b1;
    REQ   = 2'b00;
    @(negedge CLK);
    RESET = 1'b0;
    chk_idle_zero("rst_wl");
    seen = 2'b00;
    repeat (4) begin
      @(negedge CLK);
      seen = seen | DONE;
    end
    chk("rst_wl_no_done", seen, 2'b00);
    chk("rst_wl_mem", mem[8'h40], 8'h00);

    // RESET overrides REQ at the same edge
    RESET = 1'b1; REQ = 2'b10; WE = 2'b00;
    @(negedge CLK);
    RESET = 1'b0; REQ = 2'b00;
    chk("rst_ovr_gnt", GNT, 2'b00);
    chk("rst_ovr_busy", BUSY, 1'b0);
    chk("rst_ovr_oe", MEM_OE, 1'b0);

    // Continuous REQ=11: requester 0 writes 0x77 to 0x30, requester 1 reads it
    REQ = 2'b11; WE = 2'b01; ADDR = {20'h00030, 20'h00030}; WDATA = 16'h0077;
    gnt_cnt = 0; done_cnt = 0; exp_next = 1'b0; prev_done = 1'b0;
    for (int s = 1; s <= 40; s++) begin
      @(negedge CLK);
      if (prev_done) chk($sformatf("b2b_nogap_%0d", s), (GNT != 2'b00), 1'b1);
      if (GNT != 2'b00) begin
        chk($sformatf("b2b_alt_%0d", s), GNT, oh(exp_next));
        pend.push_back(int'(exp_next));
        exp_next = ~exp_next;
        gnt_cnt++;
      end
      prev_done = (DONE != 2'b00);
      if (DONE != 2'b00) begin
        done_cnt++;
        if (pend.size() == 0) begin
          chk($sformatf("b2b_extra_done_%0d", s), DONE, 2'b00);
        end else begin
          idx = pend.pop_front();
          chk($sformatf("b2b_done_%0d", s), DONE, oh(idx[0]));
          if (idx == 1) chk($sformatf("b2b_rdata_%0d", s), RDATA, 8'h77);
        end
      end
    end
    REQ = 2'b00;
    repeat (6) begin
      @(negedge CLK);
      if (DONE != 2'b00) begin
        done_cnt++;
        if (pend.size() != 0) idx = pend.pop_front();
      end
    end
    chk("b2b_gnt_count", gnt_cnt, 16);
    chk("b2b_done_count", done_cnt, 16);
    chk("b2b_pending", pend.size(), 0);

    // Random traffic: bus exclusivity, no X during reads, DONE per GNT
    viol = 0; gnt_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge CLK);
      if (MEM_OE && MEM_WRITE) viol++;
      if (MEM_OE && $isunknown(MEM_DATA)) viol++;
      if (GNT == 2'b11 || DONE == 2'b11) viol++;
      if (GNT != 2'b00) gnt_cnt++;
      if (DONE != 2'b00) done_cnt++;
      REQ   = 2'($urandom_range(0, 3));
      WE    = 2'($urandom_range(0, 3));
      ADDR  = {12'h000, 8'($urandom_range(0, 255)), 12'h000, 8'($urandom_range(0, 255))};
      WDATA = 16'($urandom_range(0, 65535));
    end
    REQ = 2'b00;
    repeat (5) begin
      @(negedge CLK);
      if (GNT != 2'b00) gnt_cnt++;
      if (DONE != 2'b00) done_cnt++;
    end
    chk("rand_bus_violations", viol, 0);
    chk("rand_done_per_gnt", done_cnt, gnt_cnt);
    chk("rand_traffic_seen", (gnt_cnt > 300), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
